// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment driver for DIGITS common-segment digits.
// It latches packed BCD/hex codes, scans one digit per SCAN_DIV-clock slot, and
// blanks both an and seg for one dead cycle at the start of every slot. It also
// supports lamp test, blanking, leading-zero blanking, optional hex glyphs and
// output polarity.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX_EN     = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  le,
    input  logic                  bl_n,
    input  logic                  lt_n,
    input  logic                  lzb,
    input  logic [4*DIGITS-1:0]   d,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    // ST_PRIME: the first enabled edge after reset emits slot 0 / cnt 0
    // without advancing, so the scan always starts with a frame pulse.
    typedef enum logic {ST_PRIME, ST_SCAN} state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   latch_q, latch_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q, frame_d;

    logic [3:0]            code;
    logic                  upper_nz;
    logic                  lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b0011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            4'd10:   g = (HEX_EN != 0) ? 7'b1110111 : 7'b0000000;
            4'd11:   g = (HEX_EN != 0) ? 7'b0011111 : 7'b0000000;
            4'd12:   g = (HEX_EN != 0) ? 7'b1001110 : 7'b0000000;
            4'd13:   g = (HEX_EN != 0) ? 7'b0111101 : 7'b0000000;
            4'd14:   g = (HEX_EN != 0) ? 7'b1001111 : 7'b0000000;
            default: g = (HEX_EN != 0) ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    // Next-state: latch, prescaler and digit index; the slot state machine.
    always_comb begin
        state_d = ST_SCAN;
        latch_d = le ? latch_q : d;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (state_q == ST_PRIME) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output glyph and enables, computed from the post-edge slot and latch data.
    always_comb begin
        seg_d    = '0;
        an_d     = '0;
        frame_d  = (cnt_d == '0) && (idx_d == '0);
        code     = latch_d[4*idx_d +: 4];
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx_d) && latch_d[4*i +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = lzb && (idx_d != '0) && !upper_nz;
        if (cnt_d != '0) begin
            an_d[idx_d] = 1'b1;
            if (!lt_n) begin
                seg_d = 7'b1111111;
            end else if (!bl_n || lz_blank) begin
                seg_d = 7'b0000000;
            end else begin
                seg_d = decode(code);
            end
        end
    end

    // Registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_PRIME;
            latch_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= '0;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign an    = (ACTIVE_LOW != 0) ? ~an_q  : an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances share inputs (plain, hex glyphs,
// active-low ports). A cycle-count reference model predicts every output.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        le = 1'b0, bl_n = 1'b1, lt_n = 1'b1, lzb = 1'b0;
    logic [15:0] d = 16'h0;

    logic [6:0] seg_p, seg_h, seg_l;
    logic [3:0] an_p, an_h, an_l;
    logic       frame_p, frame_h, frame_l;

    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(0), .ACTIVE_LOW(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .le(le), .bl_n(bl_n), .lt_n(lt_n), .lzb(lzb), .d(d),
        .seg(seg_p), .an(an_p), .frame(frame_p));
    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(1), .ACTIVE_LOW(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .le(le), .bl_n(bl_n), .lt_n(lt_n), .lzb(lzb), .d(d),
        .seg(seg_h), .an(an_h), .frame(frame_h));
    seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .HEX_EN(0), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .rst_n(rst_n), .le(le), .bl_n(bl_n), .lt_n(lt_n), .lzb(lzb), .d(d),
        .seg(seg_l), .an(an_l), .frame(frame_l));

    // ---------------- reference model ----------------
    logic [6:0] dec_tab [16];
    logic [6:0] hex_tab [16];
    logic [3:0] m_digit [DIGITS];   // latched digit codes
    bit         m_started;
    int         m_t;                // cycles since first enabled edge
    logic [6:0] e_seg_p, e_seg_h;
    logic [3:0] e_an;
    logic       e_frame;

    int checks = 0;
    int failures = 0;

    function automatic bit lz_blanked(int k);
        if (!lzb || k == 0) return 1'b0;
        for (int i = k; i < DIGITS; i++) if (m_digit[i] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int c, k;
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) m_digit[i] = 4'd0;
            m_started = 1'b0;
            e_seg_p = 7'd0; e_seg_h = 7'd0; e_an = 4'd0; e_frame = 1'b0;
            return;
        end
        if (!le) for (int i = 0; i < DIGITS; i++) m_digit[i] = d[4*i +: 4];
        m_t = m_started ? m_t + 1 : 0;
        m_started = 1'b1;
        c = m_t % SCAN_DIV;
        k = (m_t / SCAN_DIV) % DIGITS;
        e_frame = (c == 0) && (k == 0);
        e_an = 4'd0; e_seg_p = 7'd0; e_seg_h = 7'd0;
        if (c != 0) begin
            e_an = 4'(1 << k);
            if (!lt_n) begin
                e_seg_p = 7'h7F; e_seg_h = 7'h7F;
            end else if (bl_n && !lz_blanked(k)) begin
                e_seg_p = dec_tab[m_digit[k]];
                e_seg_h = hex_tab[m_digit[k]];
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("seg_plain",  {1'b0, seg_p},  {1'b0, e_seg_p});
        chk("an_plain",   {4'b0, an_p},   {4'b0, e_an});
        chk("frame_plain",{7'b0, frame_p},{7'b0, e_frame});
        chk("seg_hex",    {1'b0, seg_h},  {1'b0, e_seg_h});
        chk("an_hex",     {4'b0, an_h},   {4'b0, e_an});
        chk("seg_al",     {1'b0, seg_l},  {1'b0, ~e_seg_p});
        chk("an_al",      {4'b0, an_l},   {4'b0, ~e_an});
        chk("frame_al",   {7'b0, frame_l},{7'b0, e_frame});
    endtask

    // ---------------- driver ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic set_in(input logic r, input logic l, input logic b, input logic t,
                          input logic z, input logic [15:0] v);
        rst_n = r; le = l; bl_n = b; lt_n = t; lzb = z; d = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dec_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1111011,
                    7'b0, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0};
        hex_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1111011,
                    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        m_t = 0;
        m_started = 1'b0;

        // reset, then scan 16'h1234 over two full frames
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234);
        step(3);
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234);
        step(34);

        // latch hold, then release
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h9999);
        step(16);
        le = 1'b0;
        step(16);

        // lamp test over blank, then blank alone
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234);
        step(16);
        lt_n = 1'b1;
        step(16);

        // leading-zero blanking
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0050);
        step(16);
        d = 16'h0000;
        step(16);
        d = 16'h0700;
        step(16);

        // invalid codes / hex glyphs
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFACE);
        step(16);

        // mid-slot reset while digit 1 is active
        step(6);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            for (int j = 0; j < DIGITS; j++)
                v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            set_in(($urandom_range(0, 60) != 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0),
                   1'($urandom_range(0, 1)), v);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
